// File: rtl/tl_arb_pkg.sv
// Shared TileLink-UL constants, A-request payload, FSM state and beat helpers.
package tl_arb_pkg;

    localparam int unsigned OPC_W  = 3;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned SRC_W  = 2;
    localparam int unsigned ADDR_W = 36;
    localparam int unsigned MASK_W = 32;
    localparam int unsigned DATA_W = 256;

    localparam logic [OPC_W-1:0] PUT_FULL    = 3'd0;
    localparam logic [OPC_W-1:0] PUT_PARTIAL = 3'd1;
    localparam logic [OPC_W-1:0] GET         = 3'd4;
    localparam logic [OPC_W-1:0] ACK         = 3'd0;
    localparam logic [OPC_W-1:0] ACK_DATA    = 3'd1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [SIZE_W-1:0] size;
        logic [SRC_W-1:0]  source;
        logic [ADDR_W-1:0] address;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } a_req_t;

    // Puts carry data on A and may span several beats.
    function automatic logic has_data(input logic [OPC_W-1:0] opcode);
        return (opcode == PUT_FULL) || (opcode == PUT_PARTIAL);
    endfunction

    // Beats per message on a 32-byte bus: max(1, 2^(size-5)).
    function automatic int unsigned beats(input logic [SIZE_W-1:0] size);
        if (size <= 3'd5) begin
            return 32'd1;
        end
        return 32'd1 << (size - 3'd5);
    endfunction

endpackage

// File: rtl/tl_rr_grant2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the preferred master.
module tl_rr_grant2 (
    input  logic i_valid_0,
    input  logic i_valid_1,
    input  logic i_rr,
    output logic o_grant,
    output logic o_any
);

    assign o_grant = (i_valid_0 & i_valid_1) ? i_rr : i_valid_1;
    assign o_any   = i_valid_0 | i_valid_1;

endmodule

// File: rtl/tl_a_arbiter_2to1.sv
// 2:1 TileLink-UL arbiter: round-robin A merge with burst lock, D demux by source tag.
module tl_a_arbiter_2to1
    import tl_arb_pkg::*;
#(
    parameter int unsigned MAX_SIZE = 6,
    parameter int unsigned BEAT_W   = 2
) (
    input  logic           clock,
    input  logic           reset,

    input  logic           auto_in_0_a_valid,
    input  logic [2:0]     auto_in_0_a_opcode,
    input  logic [2:0]     auto_in_0_a_size,
    input  logic [1:0]     auto_in_0_a_source,
    input  logic [35:0]    auto_in_0_a_address,
    input  logic [31:0]    auto_in_0_a_mask,
    input  logic [255:0]   auto_in_0_a_data,
    output logic           auto_in_0_a_ready,
    input  logic           auto_in_0_d_ready,
    output logic           auto_in_0_d_valid,
    output logic [2:0]     auto_in_0_d_opcode,
    output logic [2:0]     auto_in_0_d_size,
    output logic [1:0]     auto_in_0_d_source,
    output logic           auto_in_0_d_denied,
    output logic [255:0]   auto_in_0_d_data,
    output logic           auto_in_0_d_corrupt,

    input  logic           auto_in_1_a_valid,
    input  logic [2:0]     auto_in_1_a_opcode,
    input  logic [2:0]     auto_in_1_a_size,
    input  logic [1:0]     auto_in_1_a_source,
    input  logic [35:0]    auto_in_1_a_address,
    input  logic [31:0]    auto_in_1_a_mask,
    input  logic [255:0]   auto_in_1_a_data,
    output logic           auto_in_1_a_ready,
    input  logic           auto_in_1_d_ready,
    output logic           auto_in_1_d_valid,
    output logic [2:0]     auto_in_1_d_opcode,
    output logic [2:0]     auto_in_1_d_size,
    output logic [1:0]     auto_in_1_d_source,
    output logic           auto_in_1_d_denied,
    output logic [255:0]   auto_in_1_d_data,
    output logic           auto_in_1_d_corrupt,

    output logic           auto_out_a_valid,
    output logic [2:0]     auto_out_a_opcode,
    output logic [2:0]     auto_out_a_size,
    output logic [2:0]     auto_out_a_source,
    output logic [35:0]    auto_out_a_address,
    output logic [31:0]    auto_out_a_mask,
    output logic [255:0]   auto_out_a_data,
    input  logic           auto_out_a_ready,
    input  logic           auto_out_d_valid,
    input  logic [2:0]     auto_out_d_opcode,
    input  logic [2:0]     auto_out_d_size,
    input  logic [2:0]     auto_out_d_source,
    input  logic           auto_out_d_denied,
    input  logic [255:0]   auto_out_d_data,
    input  logic           auto_out_d_corrupt,
    output logic           auto_out_d_ready
);

    state_t              r_state;
    logic                r_rr;
    logic                r_lock;
    logic [BEAT_W-1:0]   r_remain;

    state_t              w_state_nxt;
    logic                w_rr_nxt;
    logic                w_lock_nxt;
    logic [BEAT_W-1:0]   w_remain_nxt;

    logic                w_grant;
    logic                w_any;
    logic                w_sel;
    logic                w_out_valid;
    logic                w_gate;
    logic                w_fire;
    a_req_t              w_a0;
    a_req_t              w_a1;
    a_req_t              w_a_sel;
    logic [SIZE_W-1:0]   w_size_eff;
    logic [BEAT_W-1:0]   w_beats;

    assign w_a0 = {auto_in_0_a_opcode, auto_in_0_a_size, auto_in_0_a_source,
                   auto_in_0_a_address, auto_in_0_a_mask, auto_in_0_a_data};
    assign w_a1 = {auto_in_1_a_opcode, auto_in_1_a_size, auto_in_1_a_source,
                   auto_in_1_a_address, auto_in_1_a_mask, auto_in_1_a_data};

    tl_rr_grant2 u_grant (
        .i_valid_0 (auto_in_0_a_valid),
        .i_valid_1 (auto_in_1_a_valid),
        .i_rr      (r_rr),
        .o_grant   (w_grant),
        .o_any     (w_any)
    );

    // Pick the master driving A: fresh grant in IDLE, the locked master during a burst.
    always_comb begin
        w_sel       = w_grant;
        w_out_valid = w_any;
        w_gate      = w_any;
        if (r_state == BURST) begin
            w_sel       = r_lock;
            w_out_valid = r_lock ? auto_in_1_a_valid : auto_in_0_a_valid;
            w_gate      = 1'b1;
        end
    end

    assign w_a_sel    = w_sel ? w_a1 : w_a0;
    assign w_fire     = w_out_valid & auto_out_a_ready;
    assign w_size_eff = (w_a_sel.size > SIZE_W'(MAX_SIZE)) ? SIZE_W'(MAX_SIZE) : w_a_sel.size;
    assign w_beats    = BEAT_W'(beats(w_size_eff));

    assign auto_out_a_valid   = w_out_valid;
    assign auto_out_a_opcode  = w_a_sel.opcode;
    assign auto_out_a_size    = w_a_sel.size;
    assign auto_out_a_source  = {w_sel, w_a_sel.source};
    assign auto_out_a_address = w_a_sel.address;
    assign auto_out_a_mask    = w_a_sel.mask;
    assign auto_out_a_data    = w_a_sel.data;
    assign auto_in_0_a_ready  = auto_out_a_ready & w_gate & ~w_sel;
    assign auto_in_1_a_ready  = auto_out_a_ready & w_gate &  w_sel;

    // Next-state: rotate preference on message starts, lock and count multi-beat puts.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr;
        w_lock_nxt   = r_lock;
        w_remain_nxt = r_remain;
        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    w_rr_nxt = ~w_grant;
                    if (has_data(w_a_sel.opcode) && (w_beats > BEAT_W'(1))) begin
                        w_state_nxt  = BURST;
                        w_lock_nxt   = w_grant;
                        w_remain_nxt = w_beats - BEAT_W'(1);
                    end
                end
            end
            BURST: begin
                if (w_fire) begin
                    w_remain_nxt = r_remain - BEAT_W'(1);
                    if (r_remain == BEAT_W'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Arbitration state register with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_rr     <= 1'b0;
            r_lock   <= 1'b0;
            r_remain <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr     <= w_rr_nxt;
            r_lock   <= w_lock_nxt;
            r_remain <= w_remain_nxt;
        end
    end

    // Oversized requests are a protocol violation; they are handled as MAX_SIZE.
    a_size_legal: assert property (@(posedge clock) disable iff (!reset)
        !(auto_out_a_valid && (auto_out_a_size > SIZE_W'(MAX_SIZE))));

    // D responses are steered by the master tag in source[2].
    assign auto_out_d_ready    = auto_out_d_source[2] ? auto_in_1_d_ready : auto_in_0_d_ready;
    assign auto_in_0_d_valid   = auto_out_d_valid & ~auto_out_d_source[2];
    assign auto_in_1_d_valid   = auto_out_d_valid &  auto_out_d_source[2];
    assign auto_in_0_d_opcode  = auto_out_d_opcode;
    assign auto_in_1_d_opcode  = auto_out_d_opcode;
    assign auto_in_0_d_size    = auto_out_d_size;
    assign auto_in_1_d_size    = auto_out_d_size;
    assign auto_in_0_d_source  = auto_out_d_source[1:0];
    assign auto_in_1_d_source  = auto_out_d_source[1:0];
    assign auto_in_0_d_denied  = auto_out_d_denied;
    assign auto_in_1_d_denied  = auto_out_d_denied;
    assign auto_in_0_d_data    = auto_out_d_data;
    assign auto_in_1_d_data    = auto_out_d_data;
    assign auto_in_0_d_corrupt = auto_out_d_corrupt;
    assign auto_in_1_d_corrupt = auto_out_d_corrupt;

endmodule

// File: tb/tb_tl_a_arbiter_2to1.sv
// Directed self-checking bench for tl_a_arbiter_2to1.
module tb_tl_a_arbiter_2to1;

    logic         clock = 1'b0;
    logic         reset;

    logic         i0_a_valid, i1_a_valid;
    logic [2:0]   i0_a_opcode, i1_a_opcode, i0_a_size, i1_a_size;
    logic [1:0]   i0_a_source, i1_a_source;
    logic [35:0]  i0_a_address, i1_a_address;
    logic [31:0]  i0_a_mask, i1_a_mask;
    logic [255:0] i0_a_data, i1_a_data;
    logic         i0_a_ready, i1_a_ready;
    logic         i0_d_ready, i1_d_ready;
    logic         i0_d_valid, i1_d_valid;
    logic [2:0]   i0_d_opcode, i1_d_opcode, i0_d_size, i1_d_size;
    logic [1:0]   i0_d_source, i1_d_source;
    logic         i0_d_denied, i1_d_denied, i0_d_corrupt, i1_d_corrupt;
    logic [255:0] i0_d_data, i1_d_data;

    logic         o_a_valid, o_a_ready;
    logic [2:0]   o_a_opcode, o_a_size, o_a_source;
    logic [35:0]  o_a_address;
    logic [31:0]  o_a_mask;
    logic [255:0] o_a_data;
    logic         o_d_valid, o_d_ready, o_d_denied, o_d_corrupt;
    logic [2:0]   o_d_opcode, o_d_size, o_d_source;
    logic [255:0] o_d_data;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tl_a_arbiter_2to1 dut (
        .clock(clock), .reset(reset),
        .auto_in_0_a_valid(i0_a_valid), .auto_in_0_a_opcode(i0_a_opcode), .auto_in_0_a_size(i0_a_size),
        .auto_in_0_a_source(i0_a_source), .auto_in_0_a_address(i0_a_address), .auto_in_0_a_mask(i0_a_mask),
        .auto_in_0_a_data(i0_a_data), .auto_in_0_a_ready(i0_a_ready), .auto_in_0_d_ready(i0_d_ready),
        .auto_in_0_d_valid(i0_d_valid), .auto_in_0_d_opcode(i0_d_opcode), .auto_in_0_d_size(i0_d_size),
        .auto_in_0_d_source(i0_d_source), .auto_in_0_d_denied(i0_d_denied), .auto_in_0_d_data(i0_d_data),
        .auto_in_0_d_corrupt(i0_d_corrupt),
        .auto_in_1_a_valid(i1_a_valid), .auto_in_1_a_opcode(i1_a_opcode), .auto_in_1_a_size(i1_a_size),
        .auto_in_1_a_source(i1_a_source), .auto_in_1_a_address(i1_a_address), .auto_in_1_a_mask(i1_a_mask),
        .auto_in_1_a_data(i1_a_data), .auto_in_1_a_ready(i1_a_ready), .auto_in_1_d_ready(i1_d_ready),
        .auto_in_1_d_valid(i1_d_valid), .auto_in_1_d_opcode(i1_d_opcode), .auto_in_1_d_size(i1_d_size),
        .auto_in_1_d_source(i1_d_source), .auto_in_1_d_denied(i1_d_denied), .auto_in_1_d_data(i1_d_data),
        .auto_in_1_d_corrupt(i1_d_corrupt),
        .auto_out_a_valid(o_a_valid), .auto_out_a_opcode(o_a_opcode), .auto_out_a_size(o_a_size),
        .auto_out_a_source(o_a_source), .auto_out_a_address(o_a_address), .auto_out_a_mask(o_a_mask),
        .auto_out_a_data(o_a_data), .auto_out_a_ready(o_a_ready),
        .auto_out_d_valid(o_d_valid), .auto_out_d_opcode(o_d_opcode), .auto_out_d_size(o_d_size),
        .auto_out_d_source(o_d_source), .auto_out_d_denied(o_d_denied), .auto_out_d_data(o_d_data),
        .auto_out_d_corrupt(o_d_corrupt), .auto_out_d_ready(o_d_ready)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [2:0] op, input logic [2:0] sz,
                          input logic [1:0] src, input logic [35:0] addr, input logic [255:0] dat);
        i0_a_valid = v; i0_a_opcode = op; i0_a_size = sz; i0_a_source = src;
        i0_a_address = addr; i0_a_mask = '1; i0_a_data = dat;
    endtask

    task automatic drive1(input logic v, input logic [2:0] op, input logic [2:0] sz,
                          input logic [1:0] src, input logic [35:0] addr, input logic [255:0] dat);
        i1_a_valid = v; i1_a_opcode = op; i1_a_size = sz; i1_a_source = src;
        i1_a_address = addr; i1_a_mask = '1; i1_a_data = dat;
    endtask

    task automatic pulse_reset;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        drive0(1'b0, 3'd4, 3'd5, 2'd0, 36'h0, '0);
        drive1(1'b0, 3'd4, 3'd5, 2'd0, 36'h0, '0);
        o_a_ready = 1'b1; o_d_valid = 1'b0; o_d_opcode = 3'd0; o_d_size = 3'd5;
        o_d_source = 3'd0; o_d_denied = 1'b0; o_d_data = '0; o_d_corrupt = 1'b0;
        i0_d_ready = 1'b0; i1_d_ready = 1'b0;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        checks++; if (o_a_valid !== 1'b0) begin errors++; $display("FAIL reset_out_a_valid: got %0b want 0", o_a_valid); end
        checks++; if ({i0_a_ready, i1_a_ready} !== 2'b00) begin errors++; $display("FAIL reset_a_ready: got %b want 00", {i0_a_ready, i1_a_ready}); end
        checks++; if ({i0_d_valid, i1_d_valid} !== 2'b00) begin errors++; $display("FAIL reset_d_valid: got %b want 00", {i0_d_valid, i1_d_valid}); end
        tick();
    endtask

    task automatic test_single_get;
        drive1(1'b1, 3'd4, 3'd5, 2'd2, 36'h0_8000_0040, '0);
        #1;
        checks++; if (o_a_valid !== 1'b1) begin errors++; $display("FAIL get_valid: got %0b want 1", o_a_valid); end
        checks++; if (o_a_source !== 3'd6) begin errors++; $display("FAIL get_source: got %0d want 6", o_a_source); end
        checks++; if (o_a_address !== 36'h0_8000_0040) begin errors++; $display("FAIL get_address: got %h want 080000040", o_a_address); end
        checks++; if ({i0_a_ready, i1_a_ready} !== 2'b01) begin errors++; $display("FAIL get_ready: got %b want 01", {i0_a_ready, i1_a_ready}); end
        tick();
        drive1(1'b0, 3'd4, 3'd5, 2'd0, 36'h0, '0);
        o_d_valid = 1'b1; o_d_opcode = 3'd1; o_d_size = 3'd5; o_d_source = 3'd6;
        o_d_data = {8{32'hCAFE_0001}}; i1_d_ready = 1'b1; i0_d_ready = 1'b0;
        #1;
        checks++; if ({i0_d_valid, i1_d_valid} !== 2'b01) begin errors++; $display("FAIL get_d_route: got %b want 01", {i0_d_valid, i1_d_valid}); end
        checks++; if (i1_d_source !== 2'd2) begin errors++; $display("FAIL get_d_source: got %0d want 2", i1_d_source); end
        checks++; if (i1_d_opcode !== 3'd1 || i1_d_data !== {8{32'hCAFE_0001}}) begin errors++; $display("FAIL get_d_fields: got op %0d data %h", i1_d_opcode, i1_d_data); end
        checks++; if (o_d_ready !== 1'b1) begin errors++; $display("FAIL get_d_ready: got %0b want 1", o_d_ready); end
        tick();
        o_d_valid = 1'b0; i1_d_ready = 1'b0;
    endtask

    task automatic test_alternate;
        logic [3:0] exp_g;
        exp_g = 4'b1010;
        pulse_reset();
        o_a_ready = 1'b1;
        drive0(1'b1, 3'd4, 3'd5, 2'd1, 36'h100, '0);
        drive1(1'b1, 3'd4, 3'd5, 2'd3, 36'h200, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (o_a_source[2] !== exp_g[i]) begin errors++; $display("FAIL alt_grant[%0d]: got %0b want %0b", i, o_a_source[2], exp_g[i]); end
            checks++; if ({i1_a_ready, i0_a_ready} !== (exp_g[i] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_ready[%0d]: got %b", i, {i1_a_ready, i0_a_ready}); end
            tick();
        end
        drive0(1'b0, 3'd4, 3'd5, 2'd0, 36'h0, '0);
        drive1(1'b0, 3'd4, 3'd5, 2'd0, 36'h0, '0);
    endtask

    task automatic test_burst_lock;
        o_a_ready = 1'b1;
        drive0(1'b1, 3'd0, 3'd6, 2'd1, 36'h1000, {8{32'h1111_1111}});
        drive1(1'b1, 3'd4, 3'd5, 2'd0, 36'h2000, '0);
        #1;
        checks++; if (o_a_source !== 3'd1 || i0_a_ready !== 1'b1 || i1_a_ready !== 1'b0) begin errors++; $display("FAIL burst_beat1: got src %0d rdy %b", o_a_source, {i1_a_ready, i0_a_ready}); end
        tick();
        drive0(1'b1, 3'd0, 3'd6, 2'd1, 36'h1000, {8{32'h2222_2222}});
        #1;
        checks++; if (o_a_source[2] !== 1'b0 || o_a_data !== {8{32'h2222_2222}}) begin errors++; $display("FAIL burst_beat2: got src %0d data %h", o_a_source, o_a_data); end
        checks++; if (i1_a_ready !== 1'b0) begin errors++; $display("FAIL burst_block1: got %0b want 0", i1_a_ready); end
        tick();
        drive0(1'b1, 3'd4, 3'd5, 2'd1, 36'h3000, '0);
        #1;
        checks++; if (o_a_source !== 3'd4 || i1_a_ready !== 1'b1 || i0_a_ready !== 1'b0) begin errors++; $display("FAIL burst_next_grant: got src %0d rdy %b want 4/10", o_a_source, {i1_a_ready, i0_a_ready}); end
        tick();
        drive0(1'b0, 3'd4, 3'd5, 2'd0, 36'h0, '0);
        drive1(1'b0, 3'd4, 3'd5, 2'd0, 36'h0, '0);
    endtask

    task automatic test_stall;
        drive0(1'b1, 3'd1, 3'd6, 2'd2, 36'h4000, {8{32'h3333_3333}});
        drive1(1'b1, 3'd4, 3'd5, 2'd1, 36'h5000, '0);
        o_a_ready = 1'b1;
        tick();
        o_a_ready = 1'b0;
        #1;
        checks++; if (o_a_valid !== 1'b1 || o_a_source[2] !== 1'b0) begin errors++; $display("FAIL stall_hold: got v %0b src %0d", o_a_valid, o_a_source); end
        checks++; if ({i1_a_ready, i0_a_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready: got %b want 00", {i1_a_ready, i0_a_ready}); end
        tick();
        o_a_ready = 1'b1;
        #1;
        checks++; if (o_a_source[2] !== 1'b0 || {i1_a_ready, i0_a_ready} !== 2'b01) begin errors++; $display("FAIL stall_beat2: got src %0d rdy %b want 0/01", o_a_source, {i1_a_ready, i0_a_ready}); end
        tick();
        drive0(1'b0, 3'd4, 3'd5, 2'd0, 36'h0, '0);
        #1;
        checks++; if (o_a_source !== 3'd5 || i1_a_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got src %0d rdy %0b want 5/1", o_a_source, i1_a_ready); end
        tick();
        drive1(1'b0, 3'd4, 3'd5, 2'd0, 36'h0, '0);
    endtask

    task automatic test_reset_mid_burst;
        o_a_ready = 1'b1;
        drive0(1'b1, 3'd0, 3'd6, 2'd0, 36'h6000, {8{32'h4444_4444}});
        tick();
        o_a_ready = 1'b0;
        pulse_reset();
        drive0(1'b0, 3'd4, 3'd5, 2'd0, 36'h0, '0);
        drive1(1'b1, 3'd4, 3'd5, 2'd2, 36'h7000, '0);
        #1;
        checks++; if (o_a_valid !== 1'b1 || o_a_source !== 3'd6) begin errors++; $display("FAIL rst_idle: got v %0b src %0d want 1/6", o_a_valid, o_a_source); end
        drive0(1'b1, 3'd4, 3'd5, 2'd3, 36'h8000, '0);
        o_a_ready = 1'b1;
        #1;
        checks++; if (o_a_source !== 3'd3 || {i1_a_ready, i0_a_ready} !== 2'b01) begin errors++; $display("FAIL rst_rr0: got src %0d rdy %b want 3/01", o_a_source, {i1_a_ready, i0_a_ready}); end
        tick();
        checks++; if (o_a_source !== 3'd6) begin errors++; $display("FAIL rst_rr1: got src %0d want 6", o_a_source); end
        tick();
        drive0(1'b0, 3'd4, 3'd5, 2'd0, 36'h0, '0);
        drive1(1'b0, 3'd4, 3'd5, 2'd0, 36'h0, '0);
    endtask

    task automatic test_d_backpressure;
        o_d_valid = 1'b1; o_d_opcode = 3'd1; o_d_size = 3'd6; o_d_source = 3'd1;
        o_d_denied = 1'b1; o_d_corrupt = 1'b1; o_d_data = {8{32'hDEAD_BEEF}};
        i0_d_ready = 1'b0; i1_d_ready = 1'b1;
        #1;
        checks++; if (o_d_ready !== 1'b0) begin errors++; $display("FAIL dbp_stall: got %0b want 0", o_d_ready); end
        checks++; if ({i1_d_valid, i0_d_valid} !== 2'b01) begin errors++; $display("FAIL dbp_route: got %b want 01", {i1_d_valid, i0_d_valid}); end
        tick();
        i0_d_ready = 1'b1;
        #1;
        checks++; if (o_d_ready !== 1'b1) begin errors++; $display("FAIL dbp_ready: got %0b want 1", o_d_ready); end
        checks++; if (i0_d_source !== 2'd1 || i0_d_size !== 3'd6 || i0_d_denied !== 1'b1 || i0_d_corrupt !== 1'b1 || i0_d_data !== {8{32'hDEAD_BEEF}}) begin
            errors++; $display("FAIL dbp_fields: got src %0d size %0d den %0b cor %0b data %h", i0_d_source, i0_d_size, i0_d_denied, i0_d_corrupt, i0_d_data);
        end
        tick();
        o_d_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_get();
        test_alternate();
        test_burst_lock();
        test_stall();
        test_reset_mid_burst();
        test_d_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
